// File: rtl/cpu_pkg.sv
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared fetch-stage defaults and the fetch state encoding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int unsigned c_pc_w     = 8;
    localparam int unsigned c_instr_w  = 24;
    localparam int unsigned c_reset_pc = 0;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// ============================================================================
//  Module   : fetch_if
//  Brief    : ROM read port, decoder handshake and control lines of fetch.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface fetch_if #(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned INSTR_W = 24
);

    logic               rom_enable;
    logic [PC_W-1:0]    rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic               jump_en;
    logic [PC_W-1:0]    jump_addr;
    logic               halt;
    logic               halted;

    modport master (
        output rom_enable, rom_addr, instr, instr_pc, instr_valid, halted,
        input  rom_data, instr_ready, jump_en, jump_addr, halt
    );

    modport slave (
        input  rom_enable, rom_addr, instr, instr_pc, instr_valid, halted,
        output rom_data, instr_ready, jump_en, jump_addr, halt
    );

endinterface

`default_nettype wire

// File: rtl/fetch_skid.sv
// ============================================================================
//  Module   : fetch_skid
//  Brief    : Two-entry buffer: registered head (output) entry plus skid entry.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_skid #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned TAG_W  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_push,
    input  wire logic              i_pop,
    input  wire logic              i_flush,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic [TAG_W-1:0]  i_push_tag,
    output logic                   o_head_valid,
    output logic [DATA_W-1:0]      o_head_data,
    output logic [TAG_W-1:0]       o_head_tag,
    output logic [1:0]             o_occupancy
);

    logic              r_head_valid;
    logic [DATA_W-1:0] r_head_data;
    logic [TAG_W-1:0]  r_head_tag;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [TAG_W-1:0]  r_skid_tag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
            r_head_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_tag   <= '0;
        end else if (i_flush) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_pop) begin
            if (r_skid_valid) begin
                r_head_data  <= r_skid_data;
                r_head_tag   <= r_skid_tag;
                r_head_valid <= 1'b1;
                r_skid_valid <= i_push;
                if (i_push) begin
                    r_skid_data <= i_push_data;
                    r_skid_tag  <= i_push_tag;
                end
            end else begin
                r_head_valid <= i_push;
                if (i_push) begin
                    r_head_data <= i_push_data;
                    r_head_tag  <= i_push_tag;
                end
            end
        end else if (i_push) begin
            // The issuer never lets a push land on a full buffer.
            if (!r_head_valid) begin
                r_head_data  <= i_push_data;
                r_head_tag   <= i_push_tag;
                r_head_valid <= 1'b1;
            end else begin
                r_skid_data  <= i_push_data;
                r_skid_tag   <= i_push_tag;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign o_head_valid = r_head_valid;
    assign o_head_data  = r_head_data;
    assign o_head_tag   = r_head_tag;
    assign o_occupancy  = {1'b0, r_head_valid} + {1'b0, r_skid_valid};

endmodule

`default_nettype wire

// File: rtl/fetch.sv
// ============================================================================
//  Module   : fetch
//  Brief    : Instruction fetch with one-cycle ROM, 2-deep buffer, jump/halt.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fetch
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = c_pc_w,
    parameter int unsigned     INSTR_W  = c_instr_w,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(c_reset_pc)
) (
    input  wire logic clk,
    input  wire logic rst,
    fetch_if.master   bus
);

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_pc;
    logic               r_inflight;
    logic [PC_W-1:0]    r_inflight_tag;
    logic               r_halted;

    logic               w_head_valid;
    logic [INSTR_W-1:0] w_head_data;
    logic [PC_W-1:0]    w_head_tag;
    logic [1:0]         w_occupancy;
    logic               w_transfer;
    logic               w_issue;
    logic               w_flush;
    logic               w_push;

    assign w_transfer = w_head_valid && bus.instr_ready;
    // Buffer slots already spoken for (held + in flight) bound the issue rate.
    assign w_issue    = (r_state == RUN) &&
                        (((w_occupancy + {1'b0, r_inflight}) < 2'd2) || w_transfer);
    assign w_flush    = (r_state == RUN) && (bus.jump_en || bus.halt);
    assign w_push     = r_inflight && !w_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_inflight     <= 1'b0;
            r_inflight_tag <= '0;
            r_halted       <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (bus.halt) begin
                        r_state    <= HALTED;
                        r_halted   <= 1'b1;
                        r_inflight <= 1'b0;
                    end else if (bus.jump_en) begin
                        r_pc       <= bus.jump_addr;
                        r_inflight <= 1'b0;
                    end else begin
                        r_inflight <= w_issue;
                        if (w_issue) begin
                            r_inflight_tag <= r_pc;
                            r_pc           <= r_pc + 1'b1;
                        end
                    end
                end
                HALTED: r_state <= HALTED;
                default: r_state <= BOOT;
            endcase
        end
    end

    fetch_skid #(
        .DATA_W (INSTR_W),
        .TAG_W  (PC_W)
    ) u_skid (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_push),
        .i_pop        (w_transfer),
        .i_flush      (w_flush),
        .i_push_data  (bus.rom_data),
        .i_push_tag   (r_inflight_tag),
        .o_head_valid (w_head_valid),
        .o_head_data  (w_head_data),
        .o_head_tag   (w_head_tag),
        .o_occupancy  (w_occupancy)
    );

    assign bus.rom_enable  = w_issue;
    assign bus.rom_addr    = r_pc;
    assign bus.instr       = w_head_data;
    assign bus.instr_pc    = w_head_tag;
    assign bus.instr_valid = w_head_valid;
    assign bus.halted      = r_halted;

endmodule

`default_nettype wire

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL: one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter PC_W, 8, program-counter and ROM address width.
REQ-003 SHALL have parameter INSTR_W, 24, instruction width (3 bytes).
REQ-004 SHALL have parameter RESET_PC, 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port rom_enable  output  1  ROM read request this cycle.
REQ-008 SHALL have port rom_addr  output  PC_W  ROM read address.
REQ-009 SHALL have port rom_data  input  INSTR_W  ROM read data, valid exactly 1 cycle after the request.
REQ-010 SHALL have port instr  output  INSTR_W  instruction to decoder.
REQ-011 SHALL have port instr_pc  output  PC_W  address of instr.
REQ-012 SHALL have port instr_valid  output  1  instr/instr_pc valid.
REQ-013 SHALL have port instr_ready  input  1  decoder accepts; transfer = valid && ready.
REQ-014 SHALL have port jump_en  input  1  one-cycle redirect request.
REQ-015 SHALL have port jump_addr  input  PC_W  redirect target.
REQ-016 SHALL have port halt  input  1  one-cycle stop request.
REQ-017 SHALL have port halted  output  1  fetch stopped.

Function
REQ-018 SHALL implement states BOOT, RUN, HALTED; BOOT->RUN on first edge with rst high; RUN->HALTED on edge with halt=1; HALTED exits only via reset.
REQ-019 SHALL hold a 2-entry FIFO (output register + skid entry); instr/instr_pc/instr_valid driven registered from the head entry.
REQ-020 SHALL assert rom_enable in RUN when (occupancy + in-flight) < 2 or a transfer occurs this cycle; never in BOOT or HALTED.
REQ-021 SHALL drive rom_addr = pc; pc increments by 1 on each issued request, wrapping 2^PC_W-1 -> 0.
REQ-022 SHALL tag each request with its address and push rom_data with that tag into the FIFO on the following edge unless the request is stale.
REQ-023 SHALL sustain one transfer per cycle with instr_ready held high; instr_pc sequence strictly consecutive (modulo 2^PC_W).
REQ-024 SHALL hold instr/instr_pc stable while instr_valid=1 and instr_ready=0; no entry lost or duplicated.
REQ-025 SHALL on edge with jump_en=1: pc <= jump_addr, FIFO cleared, in-flight request marked stale and dropped; instr_valid=0 next cycle.
REQ-026 SHALL deliver jump target with instr_valid high two edges after the jump edge (issue cycle + capture).
REQ-027 SHALL give halt priority over simultaneous jump_en; on halt edge FIFO cleared, in-flight dropped, halted=1, instr_valid=0 from next cycle.
REQ-028 SHALL ignore jump_en and halt in BOOT and HALTED.
REQ-029 SHALL drop a same-cycle transfer together with the flush on jump/halt (the accepted entry counts as consumed).

Reset
REQ-030 SHALL on rst=0 asynchronously set state BOOT, pc=RESET_PC, FIFO empty, no in-flight, instr=0, instr_pc=0, instr_valid=0, halted=0, rom_enable=0, rom_addr=RESET_PC.
REQ-031 SHALL abandon any in-flight request when reset asserts mid-operation; first request after release is RESET_PC.

Structure
REQ-032 SHALL place PC_W, INSTR_W, RESET_PC defaults and the state enum (BOOT, RUN, HALTED) in shared package cpu_pkg.
REQ-033 SHALL implement the 2-entry buffer as sub-module fetch_skid (push, pop, flush, data+tag, valid, occupancy).

Verification
REQ-034 SHALL cover: release reset, ready=1 -> rom_enable at cycle after BOOT, instr_valid rises 3rd edge after release, instr_pc 0,1,2,3 on consecutive cycles.
REQ-035 SHALL cover: ready=0 for 5 cycles at instr_pc=4 -> instr/instr_pc held at 4, at most 2 requests outstanding, resumes 4,5,6 with no gap or duplicate.
REQ-036 SHALL cover: jump_en=1, jump_addr=0x40 while instr_pc=7 in-flight -> 7 onward discarded, next valid instr_pc=0x40 two edges after the jump edge, then 0x41.
REQ-037 SHALL cover: pc at 0xFE, ready=1 -> instr_pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-038 SHALL cover: halt=1 and jump_en=1 same cycle -> halted=1, instr_valid=0, rom_enable=0 thereafter, jump ignored.
REQ-039 SHALL cover: rst=0 mid-stream with ready=0 and FIFO full -> outputs cleared immediately, after release fetch restarts at RESET_PC=0.
